// File: rtl/uart_tx_sequencer_if.sv
// UART register port bundle between the transmit sequencer and the UART register block.
//   uart_we      write strobe
//   uart_reg_sel 0 = control register, 1 = data registers
//   uart_addr    data register select (0 = TX data, 1 = RX data)
//   uart_wdata   write data
//   uart_rdata   read data, combinational from uart_reg_sel/uart_addr; bit 0 = send
// master: the side that drives the port (sequencer); slave: the UART register block.
interface uart_tx_sequencer_if;
  logic        uart_we;
  logic        uart_reg_sel;
  logic        uart_addr;
  logic [31:0] uart_wdata;
  logic [31:0] uart_rdata;

  modport master (
    output uart_we,
    output uart_reg_sel,
    output uart_addr,
    output uart_wdata,
    input  uart_rdata
  );

  modport slave (
    input  uart_we,
    input  uart_reg_sel,
    input  uart_addr,
    input  uart_wdata,
    output uart_rdata
  );
endinterface

// File: rtl/uart_tx_sequencer.sv
// Hardware transmit sequencer for the memory-mapped UART register block.
// Bytes pushed by the CPU are queued in a small circular FIFO; for each byte the sequencer
// writes the TX data register, sets the send bit in the control register and polls until the
// UART clears it, with a per-byte poll timeout that raises a sticky error flag.
//
// Ports:
//   clk_i         system clock, all state changes on the rising edge
//   rst_i         synchronous active-high reset
//   tx_valid_i    CPU push request
//   tx_data_i     byte to push
//   tx_ready_o    FIFO can accept a byte (count < FIFO_DEPTH)
//   busy_o        FIFO non-empty or sequencer not idle; selects the UART port mux upstream
//   fifo_count_o  bytes stored
//   tx_done_o     one-cycle pulse per byte whose send bit was seen cleared
//   err_o         sticky poll-timeout flag
//   err_clr_i     clears err_o (a same-cycle timeout wins)
//   uart_io       UART register port (master side)
module uart_tx_sequencer #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          tx_valid_i,
  input  logic [7:0]                    tx_data_i,
  output logic                          tx_ready_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          tx_done_o,
  output logic                          err_o,
  input  logic                          err_clr_i,
  uart_tx_sequencer_if.master           uart_io
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES);

  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);
  localparam logic [TmoW-1:0] TmoLast  = TmoW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StWrData, StWrCtrl, StPoll} state_e;

  state_e          state_q, state_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic            push, pop, tmo_hit;
  logic            we, reg_sel;
  logic [31:0]     wdata;

  logic            unused_rdata;
  assign unused_rdata = ^uart_io.uart_rdata[31:1];

  // Full is judged on the stored count alone: a pop in the same cycle does not open a slot.
  assign tx_ready_o = (count_q < DepthCnt);
  assign push       = tx_valid_i && tx_ready_o;

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    done_d  = 1'b0;
    tmo_hit = 1'b0;
    pop     = 1'b0;
    we      = 1'b0;
    reg_sel = 1'b0;
    wdata   = 32'h0;
    unique case (state_q)
      StIdle: begin
        // Leave idle on the push edge itself so a byte into an empty block is written the
        // very next cycle; queued bytes still spend one idle cycle between transfers.
        if (count_q != '0 || push) begin
          state_d = StWrData;
        end
      end
      StWrData: begin
        we      = 1'b1;
        reg_sel = 1'b1;
        wdata   = {24'h0, mem_q[rd_ptr_q]};
        pop     = 1'b1;
        state_d = StWrCtrl;
      end
      StWrCtrl: begin
        we      = 1'b1;
        wdata   = 32'h0000_0001;
        tmo_d   = '0;
        state_d = StPoll;
      end
      StPoll: begin
        if (!uart_io.uart_rdata[0]) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (tmo_q == TmoLast) begin
          // Byte is abandoned, not retried.
          tmo_hit = 1'b1;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (tmo_hit) begin
      err_d = 1'b1;
    end else if (err_clr_i) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tmo_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tmo_q   <= tmo_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

  // Storage needs no reset; only slots below the count are ever read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tx_data_i;
    end
  end

  assign busy_o       = (count_q != '0) || (state_q != StIdle);
  assign fifo_count_o = count_q;
  assign tx_done_o    = done_q;
  assign err_o        = err_q;

  assign uart_io.uart_we      = we;
  assign uart_io.uart_reg_sel = reg_sel;
  assign uart_io.uart_addr    = 1'b0;
  assign uart_io.uart_wdata   = wdata;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
module tb_uart_tx_sequencer;
  localparam int unsigned Depth = 4;
  localparam int unsigned Tmo   = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       err_clr;
  logic       tx_ready, busy, tx_done, err;
  logic [2:0] fifo_count;

  uart_tx_sequencer_if uart_bus ();

  uart_tx_sequencer #(
    .FIFO_DEPTH    (Depth),
    .TIMEOUT_CYCLES(Tmo)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .tx_valid_i  (tx_valid),
    .tx_data_i   (tx_data),
    .tx_ready_o  (tx_ready),
    .busy_o      (busy),
    .fifo_count_o(fifo_count),
    .tx_done_o   (tx_done),
    .err_o       (err),
    .err_clr_i   (err_clr),
    .uart_io     (uart_bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // UART model: send bit reads 1 for busy_polls cycles after the control write.
  int unsigned busy_polls = 0;
  int unsigned busy_cnt;
  always @(posedge clk) begin
    if (rst) busy_cnt <= 0;
    else if (uart_bus.uart_we && !uart_bus.uart_reg_sel && uart_bus.uart_wdata[0])
      busy_cnt <= busy_polls;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign uart_bus.uart_rdata = (!uart_bus.uart_reg_sel && busy_cnt != 0) ? 32'h1 : 32'h0;

  // Scoreboard: expected bytes queued at the accepting edge, popped on each TX data write.
  logic [7:0]  exp_q [$];
  int unsigned cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) exp_q.delete();
    else if (tx_valid && tx_ready) exp_q.push_back(tx_data);
  end

  int unsigned done_cnt    = 0;
  int unsigned last_wr_cyc = 0;
  bit          gap_chk     = 1'b0;
  bit          want_ctrl   = 1'b0;
  logic [7:0]  exp_b;
  always @(negedge clk) begin
    if (uart_bus.uart_we && uart_bus.uart_reg_sel) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL wr_data_unexpected: got %0h, expected no write", uart_bus.uart_wdata);
      end else begin
        exp_b = exp_q.pop_front();
        check("wr_data", uart_bus.uart_wdata, {24'h0, exp_b});
        check("wr_addr", 32'(uart_bus.uart_addr), 32'h0);
      end
      if (gap_chk && last_wr_cyc != 0) check("byte_gap", cyc - last_wr_cyc, 32'd4);
      last_wr_cyc = cyc;
      want_ctrl   = 1'b1;
    end else if (want_ctrl) begin
      check("wr_ctrl_sel", {29'h0, uart_bus.uart_we, uart_bus.uart_reg_sel, uart_bus.uart_addr},
            32'h4);
      check("wr_ctrl_wdata", uart_bus.uart_wdata, 32'h1);
      want_ctrl = 1'b0;
    end
    if (tx_done === 1'b1) done_cnt++;
  end

  // Caller sits at a negedge; returns at the negedge after the accepting edge.
  task automatic push_one(input logic [7:0] b);
    int w = 0;
    while (!tx_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) check("push_ready_timeout", 32'(w), 32'd0);
    tx_valid = 1'b1;
    tx_data  = b;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_cleared", 32'(err), 32'h0);
  endtask

  task automatic wait_dones(input int unsigned base, input int unsigned want);
    int n = 0;
    while (done_cnt - base < want && n < 1000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("done_count", done_cnt - base, want);
  endtask

  typedef struct {
    logic [7:0]  data;
    int unsigned polls;
    bit          exp_err;
    int unsigned exp_lat;  // cycles from push edge to done/err cycle
  } vec_t;

  vec_t vecs[5];

  initial begin
    int unsigned lat;
    int unsigned d0;
    int n;

    vecs[0] = '{data: 8'h48, polls: 10, exp_err: 1'b0, exp_lat: 14};
    vecs[1] = '{data: 8'h00, polls: 0,  exp_err: 1'b0, exp_lat: 4};
    vecs[2] = '{data: 8'hFF, polls: 3,  exp_err: 1'b0, exp_lat: 7};
    vecs[3] = '{data: 8'hA5, polls: 15, exp_err: 1'b0, exp_lat: 19};
    vecs[4] = '{data: 8'h5A, polls: 16, exp_err: 1'b1, exp_lat: 19};

    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(tx_ready), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_count", 32'(fifo_count), 32'h0);
    check("rst_done", 32'(tx_done), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_uart", {29'h0, uart_bus.uart_we, uart_bus.uart_reg_sel, uart_bus.uart_addr}, 32'h0);
    check("rst_wdata", uart_bus.uart_wdata, 32'h0);
    rst = 1'b0;

    // Single bytes: latency, done vs timeout, boundary poll counts.
    for (int i = 0; i < 5; i++) begin
      busy_polls = vecs[i].polls;
      push_one(vecs[i].data);
      check("busy_after_push", 32'(busy), 32'h1);
      lat = 1;
      while (!(tx_done || err) && lat <= 40) begin
        @(negedge clk);
        lat++;
      end
      check("vec_lat", lat, vecs[i].exp_lat);
      check("vec_err", 32'(err), 32'(vecs[i].exp_err));
      check("vec_done", 32'(tx_done), 32'(!vecs[i].exp_err));
      check("vec_idle_busy", 32'(busy), 32'h0);
      check("vec_idle_count", 32'(fifo_count), 32'h0);
      @(negedge clk);
      check("done_one_cycle", 32'(tx_done), 32'h0);
      clear_err();
    end

    // "Hello" with a slow UART, then a push held against a full FIFO across a pop.
    busy_polls = 10;
    d0 = done_cnt;
    push_one(8'h48); push_one(8'h65); push_one(8'h6C); push_one(8'h6C); push_one(8'h6F);
    check("full_count", 32'(fifo_count), 32'd4);
    check("full_ready", 32'(tx_ready), 32'h0);
    tx_valid = 1'b1;
    tx_data  = 8'h21;
    n = 0;
    while (!(uart_bus.uart_we && uart_bus.uart_reg_sel) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("full_pop_ready", 32'(tx_ready), 32'h0);
    @(negedge clk);
    check("full_pop_refused", 32'(fifo_count), 32'd3);
    @(negedge clk);
    tx_valid = 1'b0;
    check("push_after_pop", 32'(fifo_count), 32'd4);
    wait_dones(d0, 6);
    check("hello_drained", 32'(exp_q.size()), 32'h0);
    check("hello_busy", 32'(busy), 32'h0);

    // Timeout with err_clr in the same cycle; the queued byte still goes out.
    busy_polls = 1000;
    push_one(8'hC3);           // cycle 1
    push_one(8'h21);           // cycle 2
    @(negedge clk);            // cycle 3: control write already loaded the stuck model
    busy_polls = 0;
    repeat (15) @(negedge clk); // cycle 18: last poll
    check("no_err_before_timeout", 32'(err), 32'h0);
    err_clr = 1'b1;
    @(negedge clk);            // cycle 19
    err_clr = 1'b0;
    check("err_set_wins", 32'(err), 32'h1);
    check("timeout_no_done", 32'(tx_done), 32'h0);
    d0 = done_cnt;
    wait_dones(d0, 1);
    check("err_sticky", 32'(err), 32'h1);
    clear_err();

    // Reset during POLL with two bytes queued.
    busy_polls = 1000;
    push_one(8'hA1); push_one(8'hA2); push_one(8'hA3);
    check("queued_two", 32'(fifo_count), 32'd2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_count", 32'(fifo_count), 32'h0);
    check("mid_rst_ready", 32'(tx_ready), 32'h1);
    check("mid_rst_err", 32'(err), 32'h0);
    check("mid_rst_uart", {29'h0, uart_bus.uart_we, uart_bus.uart_reg_sel, uart_bus.uart_addr},
          32'h0);
    check("mid_rst_wdata", uart_bus.uart_wdata, 32'h0);
    d0 = done_cnt;
    repeat (20) @(negedge clk);
    check("mid_rst_no_done", done_cnt - d0, 32'd0);
    check("mid_rst_stays_idle", 32'(busy), 32'h0);

    // Pointer wrap: 11 bytes, immediate completion, 4 cycles per byte in steady state.
    busy_polls  = 0;
    last_wr_cyc = 0;
    gap_chk     = 1'b1;
    d0 = done_cnt;
    for (int i = 0; i < 11; i++) push_one(8'h30 + 8'(i));
    wait_dones(d0, 11);
    gap_chk = 1'b0;
    check("wrap_drained", 32'(exp_q.size()), 32'h0);
    check("wrap_count", 32'(fifo_count), 32'h0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

endmodule
